// File: rtl/sad_pkg.sv
// Shared definitions for the SAD engine: datapath geometry and controller state.
//   DATA_W : pixel width of the A/B memory words
//   DEPTH  : pixel pairs per SAD run
//   ADDR_W : memory address width
//   SUM_W  : accumulator/result width, sized so a full run cannot overflow
package sad_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned SUM_W  = DATA_W + ADDR_W;

  // Index counter needs one extra bit so it can sit at DEPTH after the last pair.
  localparam int unsigned IDX_W  = ADDR_W + 1;

  // Controller states, shared so controller and datapath agree on the sequence:
  //   S0 idle, S1 clear, S2 loop test, S3 accumulate, S4 final load.
  typedef enum logic [2:0] {
    SAD_S0 = 3'd0,
    SAD_S1 = 3'd1,
    SAD_S2 = 3'd2,
    SAD_S3 = 3'd3,
    SAD_S4 = 3'd4
  } sad_state_e;

endpackage : sad_pkg

// File: rtl/sad_datapath_if.sv
// Controller/memory-facing bus of the SAD datapath.
//   master : controller + memory side (drives strobes and read data)
//   slave  : datapath side (drives addresses, read enables, status, result)
interface sad_datapath_if;
  import sad_pkg::*;

  // Control strobes from the controller
  logic              AB_rd;
  logic              i_inc;
  logic              i_clr;
  logic              sum_ld;
  logic              sum_clr;
  logic              sadreg_ld;
  logic              sadreg_clr;

  // Status back to the controller
  logic              i_lt_256;

  // Memory read ports (asynchronous read)
  logic              A_rd;
  logic              B_rd;
  logic [ADDR_W-1:0] A_addr;
  logic [ADDR_W-1:0] B_addr;
  logic [DATA_W-1:0] A_data;
  logic [DATA_W-1:0] B_data;

  // Result
  logic [SUM_W-1:0]  sad;
  logic              sad_valid;

  modport master (
    output AB_rd, i_inc, i_clr, sum_ld, sum_clr, sadreg_ld, sadreg_clr,
    output A_data, B_data,
    input  i_lt_256, A_rd, B_rd, A_addr, B_addr, sad, sad_valid
  );

  modport slave (
    input  AB_rd, i_inc, i_clr, sum_ld, sum_clr, sadreg_ld, sadreg_clr,
    input  A_data, B_data,
    output i_lt_256, A_rd, B_rd, A_addr, B_addr, sad, sad_valid
  );

endinterface : sad_datapath_if

// File: rtl/sad_absdiff.sv
// Combinational unsigned absolute difference |a - b|.
//   a, b   : unsigned operands, DATA_W bits
//   diff_c : |a - b|, DATA_W bits (always fits, no sign needed)
module sad_absdiff #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] diff_c
);

  // Subtract the smaller from the larger so the result never wraps.
  always_comb begin
    diff_c = '0;
    if (a >= b) begin
      diff_c = a - b;
    end else begin
      diff_c = b - a;
    end
  end

endmodule : sad_absdiff

// File: rtl/sad_datapath.sv
// SAD engine datapath: block index counter, A/B read addressing, |A-B|
// accumulator and SAD result register, stepped by the controller's strobes.
//   clk        : clock, all state on rising edge
//   rst        : asynchronous reset, active-low
//   bus.slave  : strobes in (AB_rd, i_inc/i_clr, sum_ld/sum_clr,
//                sadreg_ld/sadreg_clr), memory data in (A_data, B_data),
//                i_lt_256 status out, memory read enables/addresses out,
//                sad result and sad_valid out
// i_lt_256, A/B addresses and read enables are combinational from registered
// state / strobes so the asynchronous-read memories answer in the same cycle.
module sad_datapath
  import sad_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  sad_datapath_if.slave  bus
);

  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0] ONE_IDX   = IDX_W'(1);

  logic [IDX_W-1:0]  i_q;
  logic [SUM_W-1:0]  sum_q;
  logic [SUM_W-1:0]  sadreg_q;
  logic              sad_valid_q;
  logic [DATA_W-1:0] diff_c;
  logic              i_lt_c;

  // Pixel difference of the pair at the current index.
  sad_absdiff #(
    .DATA_W (DATA_W)
  ) u_absdiff (
    .a      (bus.A_data),
    .b      (bus.B_data),
    .diff_c (diff_c)
  );

  assign i_lt_c = (i_q < DEPTH_IDX);

  // Index counter: clear wins over increment; parks at DEPTH instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_q <= '0;
    end else if (bus.i_clr) begin
      i_q <= '0;
    end else if (bus.i_inc && i_lt_c) begin
      i_q <= i_q + ONE_IDX;
    end
  end

  // Accumulator: SUM_W is wide enough for DEPTH maximal differences.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else if (bus.sum_clr) begin
      sum_q <= '0;
    end else if (bus.sum_ld) begin
      sum_q <= sum_q + SUM_W'(diff_c);
    end
  end

  // Result register captures the pre-update sum; the load issued once the
  // index has reached DEPTH is the final one and marks the result valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sadreg_q    <= '0;
      sad_valid_q <= 1'b0;
    end else if (bus.sadreg_clr) begin
      sadreg_q    <= '0;
      sad_valid_q <= 1'b0;
    end else if (bus.sadreg_ld) begin
      sadreg_q <= sum_q;
      if (!i_lt_c) begin
        sad_valid_q <= 1'b1;
      end
    end
  end

  assign bus.i_lt_256  = i_lt_c;
  assign bus.A_addr    = i_q[ADDR_W-1:0];
  assign bus.B_addr    = i_q[ADDR_W-1:0];
  assign bus.A_rd      = bus.AB_rd;
  assign bus.B_rd      = bus.AB_rd;
  assign bus.sad       = sadreg_q;
  assign bus.sad_valid = sad_valid_q;

endmodule : sad_datapath

// File: tb/tb_sad_datapath.sv
// Directed bench for sad_datapath with an integer reference model and
// external A/B memories modelled as arrays with combinational read.
module tb_sad_datapath;
  import sad_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sad_datapath_if bus ();

  sad_datapath dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // External memories
  logic [DATA_W-1:0] a_mem [DEPTH];
  logic [DATA_W-1:0] b_mem [DEPTH];

  assign bus.A_data = a_mem[bus.A_addr];
  assign bus.B_data = b_mem[bus.B_addr];

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integers following the behavioural rules.
  int m_i     = 0;
  int m_sum   = 0;
  int m_sad   = 0;
  int m_valid = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_i     <= 0;
      m_sum   <= 0;
      m_sad   <= 0;
      m_valid <= 0;
    end else begin
      int d;
      d = int'(a_mem[m_i % DEPTH]) - int'(b_mem[m_i % DEPTH]);
      if (d < 0) d = -d;
      if (bus.i_clr) m_i <= 0;
      else if (bus.i_inc && m_i < int'(DEPTH)) m_i <= m_i + 1;
      if (bus.sum_clr) m_sum <= 0;
      else if (bus.sum_ld) m_sum <= m_sum + d;
      if (bus.sadreg_clr) begin
        m_sad   <= 0;
        m_valid <= 0;
      end else if (bus.sadreg_ld) begin
        m_sad <= m_sum;
        if (m_i >= int'(DEPTH)) m_valid <= 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("i_lt_256",  int'(bus.i_lt_256), (m_i < int'(DEPTH)) ? 1 : 0);
      chk("A_addr",    int'(bus.A_addr), m_i % int'(DEPTH));
      chk("B_addr",    int'(bus.B_addr), m_i % int'(DEPTH));
      chk("A_rd",      int'(bus.A_rd), int'(bus.AB_rd));
      chk("B_rd",      int'(bus.B_rd), int'(bus.AB_rd));
      chk("sad",       int'(bus.sad), m_sad);
      chk("sad_valid", int'(bus.sad_valid), m_valid);
    end
  end

  task automatic idle();
    bus.AB_rd = 1'b0; bus.i_inc = 1'b0; bus.i_clr = 1'b0;
    bus.sum_ld = 1'b0; bus.sum_clr = 1'b0;
    bus.sadreg_ld = 1'b0; bus.sadreg_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Controller S1: clear everything.
  task automatic s1();
    idle();
    bus.i_clr = 1'b1; bus.sum_clr = 1'b1; bus.sadreg_clr = 1'b1;
    tick();
    idle();
  endtask

  // Controller S3 repeated n times: read, accumulate, advance, stage old sum.
  task automatic s3(input int n);
    for (int k = 0; k < n; k++) begin
      idle();
      bus.AB_rd = 1'b1; bus.sum_ld = 1'b1; bus.i_inc = 1'b1; bus.sadreg_ld = 1'b1;
      tick();
    end
    idle();
  endtask

  // Controller S4: final load.
  task automatic s4();
    idle();
    bus.sadreg_ld = 1'b1;
    tick();
    idle();
  endtask

  // mode 0: A=k,B=0  1: A=0,B=255  2: A=255,B=0  3: A=B random
  task automatic fill(input int mode);
    for (int k = 0; k < int'(DEPTH); k++) begin
      case (mode)
        0: begin a_mem[k] = DATA_W'(k); b_mem[k] = '0; end
        1: begin a_mem[k] = '0; b_mem[k] = '1; end
        2: begin a_mem[k] = '1; b_mem[k] = '0; end
        default: begin a_mem[k] = DATA_W'($urandom_range(0, 255)); b_mem[k] = a_mem[k]; end
      endcase
    end
  endtask

  task automatic full_run(input int exp_sad, input string name);
    s1();
    s3(int'(DEPTH));
    chk({name, "_ilt_after_loop"}, int'(bus.i_lt_256), 0);
    chk({name, "_valid_before_s4"}, int'(bus.sad_valid), 0);
    s4();
    chk({name, "_sad"}, int'(bus.sad), exp_sad);
    chk({name, "_valid"}, int'(bus.sad_valid), 1);
  endtask

  initial begin
    idle();
    fill(0);
    #2 rst = 1'b0;
    #1 check_en = 1'b1;

    // Reset held with random strobes
    for (int k = 0; k < 5; k++) begin
      bus.AB_rd = 1'($urandom); bus.i_inc = 1'($urandom); bus.i_clr = 1'($urandom);
      bus.sum_ld = 1'($urandom); bus.sum_clr = 1'($urandom);
      bus.sadreg_ld = 1'($urandom); bus.sadreg_clr = 1'($urandom);
      tick();
    end
    chk("rst_sad", int'(bus.sad), 0);
    chk("rst_valid", int'(bus.sad_valid), 0);
    chk("rst_ilt", int'(bus.i_lt_256), 1);
    idle();
    rst = 1'b1;
    tick();
    chk("post_rst_ilt", int'(bus.i_lt_256), 1);
    chk("post_rst_addr", int'(bus.A_addr), 0);

    // Full run A=k, B=0, with latency checks
    s1();
    s3(100);
    chk("run0_addr100", int'(bus.A_addr), 100);
    s3(156);
    chk("run0_sad_prev_sum", int'(bus.sad), 32385);
    chk("run0_ilt_fell", int'(bus.i_lt_256), 0);
    chk("run0_valid_late", int'(bus.sad_valid), 0);
    s4();
    chk("run0_sad", int'(bus.sad), 32640);
    chk("run0_valid", int'(bus.sad_valid), 1);

    // Index holds at DEPTH under continued increments
    bus.i_inc = 1'b1;
    tick(); tick(); tick();
    chk("hold_ilt", int'(bus.i_lt_256), 0);
    chk("hold_addr", int'(bus.A_addr), 0);
    idle();

    // All clears beat all loads
    bus.i_clr = 1'b1; bus.i_inc = 1'b1; bus.sum_clr = 1'b1; bus.sum_ld = 1'b1;
    bus.sadreg_clr = 1'b1; bus.sadreg_ld = 1'b1;
    tick();
    idle();
    chk("prio_sad", int'(bus.sad), 0);
    chk("prio_valid", int'(bus.sad_valid), 0);
    chk("prio_ilt", int'(bus.i_lt_256), 1);
    bus.sadreg_ld = 1'b1;
    tick();
    idle();
    chk("prio_sum_zero", int'(bus.sad), 0);

    // Maximum value, both orientations
    fill(1);
    full_run(65280, "max_ab");
    fill(2);
    full_run(65280, "max_ba");

    // Mid-run reset at i=100 with strobes still active
    fill(0);
    s1();
    s3(100);
    bus.AB_rd = 1'b1; bus.sum_ld = 1'b1; bus.i_inc = 1'b1; bus.sadreg_ld = 1'b1;
    rst = 1'b0;
    #1;
    chk("midrst_addr", int'(bus.A_addr), 0);
    chk("midrst_ilt", int'(bus.i_lt_256), 1);
    chk("midrst_sad", int'(bus.sad), 0);
    chk("midrst_valid", int'(bus.sad_valid), 0);
    tick(); tick();
    idle();
    rst = 1'b1;
    tick();
    full_run(32640, "after_rst");

    // Back-to-back: S1 drops the previous result, then a zero-SAD run
    s1();
    chk("b2b_clr_valid", int'(bus.sad_valid), 0);
    chk("b2b_clr_sad", int'(bus.sad), 0);
    fill(3);
    full_run(0, "b2b_equal");

    tick(); tick();
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sad_datapath
